// File: rtl/falafel_pkg.sv
// Shared types and widths for the falafel allocator request frontend.
package falafel_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } req_op_t;

endpackage

// File: rtl/falafel_req_frontend_if.sv
// Host-side request/response handshake bundle for the allocator frontend.
interface falafel_req_frontend_if
    import falafel_pkg::*;
(
    input logic clk
);

    logic              req_val;
    logic              req_rdy;
    req_op_t           req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_val;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        input  clk,
        output req_val, req_op, req_data, rsp_rdy,
        input  req_rdy, rsp_val, rsp_data
    );

    modport slave (
        input  clk,
        input  req_val, req_op, req_data, rsp_rdy,
        output req_rdy, rsp_val, rsp_data
    );

endinterface

// File: rtl/falafel_fifo.sv
// First-word-fall-through FIFO; push when full and pop when empty are ignored,
// and full/empty come from the registered count so a pop never frees a slot for the same cycle's push.
module falafel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign dout   = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents are left as-is across reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/falafel_req_frontend.sv
// Splits host requests into alloc/free queues for the core and returns core responses to the host.
module falafel_req_frontend
    import falafel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              host_req_val_i,
    output logic              host_req_rdy_o,
    input  req_op_t           host_req_op_i,
    input  logic [DATA_W-1:0] host_req_data_i,
    output logic              alloc_fifo_empty_o,
    input  logic              alloc_fifo_read_i,
    output logic [DATA_W-1:0] alloc_fifo_dout_o,
    output logic              free_fifo_empty_o,
    input  logic              free_fifo_read_i,
    output logic [DATA_W-1:0] free_fifo_dout_o,
    output logic              resp_fifo_full_o,
    input  logic              resp_fifo_write_i,
    input  logic [DATA_W-1:0] resp_fifo_din_i,
    output logic              host_rsp_val_o,
    input  logic              host_rsp_rdy_i,
    output logic [DATA_W-1:0] host_rsp_data_o,
    output logic              resp_overflow_o,
    output logic              busy_o
);

    logic alloc_full_s;
    logic free_full_s;
    logic resp_empty_s;
    logic req_fire_s;
    logic alloc_push_s;
    logic free_push_s;
    logic rsp_pop_s;
    logic overflow_r;

    // Ready reflects only the queue the presented op targets.
    always_comb begin
        host_req_rdy_o = 1'b0;
        case (host_req_op_i)
            OP_ALLOC: host_req_rdy_o = ~alloc_full_s;
            OP_FREE:  host_req_rdy_o = ~free_full_s;
            default:  host_req_rdy_o = 1'b0;
        endcase
    end

    assign req_fire_s     = host_req_val_i & host_req_rdy_o;
    assign alloc_push_s   = req_fire_s & (host_req_op_i == OP_ALLOC);
    assign free_push_s    = req_fire_s & (host_req_op_i == OP_FREE);
    assign host_rsp_val_o = ~resp_empty_s;
    assign rsp_pop_s      = host_rsp_val_o & host_rsp_rdy_i;

    falafel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_alloc_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (alloc_push_s),
        .din   (host_req_data_i),
        .pop   (alloc_fifo_read_i),
        .full  (alloc_full_s),
        .empty (alloc_fifo_empty_o),
        .dout  (alloc_fifo_dout_o)
    );

    falafel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_free_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (free_push_s),
        .din   (host_req_data_i),
        .pop   (free_fifo_read_i),
        .full  (free_full_s),
        .empty (free_fifo_empty_o),
        .dout  (free_fifo_dout_o)
    );

    // A write while full is dropped inside the FIFO; only the overflow flag records it.
    falafel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_resp_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (resp_fifo_write_i),
        .din   (resp_fifo_din_i),
        .pop   (rsp_pop_s),
        .full  (resp_fifo_full_o),
        .empty (resp_empty_s),
        .dout  (host_rsp_data_o)
    );

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_r <= 1'b0;
        end else if (resp_fifo_write_i && resp_fifo_full_o) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign resp_overflow_o = overflow_r;
    assign busy_o          = ~(alloc_fifo_empty_o & free_fifo_empty_o & resp_empty_s);

endmodule

// File: doc/falafel_req_frontend.md
FALAFEL_REQ_FRONTEND -- requirements
Module: falafel_req_frontend

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO; power of two, >= 2.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port host_req_val_i  input  1  host request valid.
REQ-005 SHALL have port host_req_rdy_o  output  1  frontend can accept the presented request.
REQ-006 SHALL have port host_req_op_i  input  req_op_t  OP_ALLOC or OP_FREE.
REQ-007 SHALL have port host_req_data_i  input  DATA_W  alloc size or free pointer.
REQ-008 SHALL have ports alloc_fifo_empty_o  output  1, alloc_fifo_read_i  input  1, alloc_fifo_dout_o  output  DATA_W  core-side alloc queue.
REQ-009 SHALL have ports free_fifo_empty_o  output  1, free_fifo_read_i  input  1, free_fifo_dout_o  output  DATA_W  core-side free queue.
REQ-010 SHALL have ports resp_fifo_full_o  output  1, resp_fifo_write_i  input  1, resp_fifo_din_i  input  DATA_W  core-side response queue.
REQ-011 SHALL have ports host_rsp_val_o  output  1, host_rsp_rdy_i  input  1, host_rsp_data_o  output  DATA_W  host response.
REQ-012 SHALL have port resp_overflow_o  output  1  sticky: core wrote to a full response FIFO.
REQ-013 SHALL have port busy_o  output  1  any of the three FIFOs non-empty.

Function
REQ-014 SHALL hold three independent FIFOs (alloc, free, resp), each FIFO_DEPTH x DATA_W, first-word-fall-through: dout = head entry whenever non-empty.
REQ-015 host_req_rdy_o SHALL equal NOT full of the FIFO selected by host_req_op_i (combinational from op and registered count).
REQ-016 On host_req_val_i & host_req_rdy_o, host_req_data_i SHALL be pushed into the alloc FIFO (OP_ALLOC) or free FIFO (OP_FREE); visible on dout, empty deasserted, the next cycle.
REQ-017 alloc/free read_i while empty SHALL be ignored (no pointer or count change).
REQ-018 Simultaneous push and pop on a non-empty FIFO SHALL leave count unchanged and SHALL be legal when full (ready is computed before pop, so no push occurs when full).
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH (width $clog2(FIFO_DEPTH)+1).
REQ-020 resp_fifo_write_i while resp FIFO full SHALL drop the data, leave the FIFO unchanged and set resp_overflow_o the next cycle; cleared only by reset.
REQ-021 host_rsp_val_o SHALL equal resp FIFO non-empty; host_rsp_data_o = head; pop on host_rsp_val_o & host_rsp_rdy_i.
REQ-022 Resp write and host pop in the same cycle SHALL leave count unchanged; when full, the pop SHALL NOT make room for that cycle's write (write dropped, overflow set).
REQ-023 Ordering SHALL be FIFO within each queue; no ordering between alloc and free queues.
REQ-024 busy_o SHALL be registered-count based: high iff any count != 0.

Reset
REQ-025 While rst_ni = 0 at a clock edge, all pointers and counts SHALL clear to 0 and resp_overflow_o to 0; FIFO storage need not clear.
REQ-026 After reset: host_req_rdy_o = 1, alloc/free empty_o = 1, resp_fifo_full_o = 0, host_rsp_val_o = 0, busy_o = 0; reset mid-operation discards all queued entries.

Structure
REQ-027 req_op_t (1 bit: OP_ALLOC = 0, OP_FREE = 1) SHALL be defined in falafel_pkg; DATA_W SHALL come from falafel_pkg.
REQ-028 One sub-module falafel_fifo (parameters DEPTH, WIDTH; push, pop, full, empty, dout) SHALL be instantiated three times.

Verification (FIFO_DEPTH = 4)
REQ-029 Push ALLOC 0x40, FREE 0x1000, ALLOC 0x80 -> alloc dout 0x40 then 0x80 on successive reads; free dout 0x1000; empties deassert one cycle after push.
REQ-030 Push 4 ALLOCs, no reads -> rdy_o = 0 for OP_ALLOC, = 1 for OP_FREE; 5th ALLOC held; read one -> 5th accepted next cycle.
REQ-031 Full alloc FIFO, read_i and push same cycle -> count stays 4... no: push blocked (rdy 0), count becomes 3; non-full FIFO with count 2, push+pop -> count 2, order preserved.
REQ-032 Core writes 5 responses 0xA..0xE, host_rsp_rdy_i = 0 -> resp_fifo_full_o after 4th; 0xE dropped; resp_overflow_o = 1; host then drains 0xA..0xD.
REQ-033 Read_i on empty alloc FIFO -> no change; then push 0x10 -> dout 0x10 next cycle.
REQ-034 Assert rst_ni = 0 with 2 entries in each FIFO and overflow set -> all empty, overflow 0, busy_o 0 after one edge.
